// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - writeback request, register file write and hazard bundle
//
// Purpose: groups every signal of regfile_wb_ctrl except clk/rst.
// Ports (master = producer/decoder side, slave = regfile_wb_ctrl):
//   in_valid/in_ready/in_rd/in_data  writeback request handshake
//   wb_stall                         register file busy this cycle
//   rd/wr_data/wr_en                 registered register file write port
//   rs/rt, hz_a/hz_b, fwd_a/fwd_b    decoder read selects, hazard flags, forwarded data
//   count                            pending entry count 0..4
interface regfile_wb_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_stall;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hz_a;
  logic        hz_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [2:0]  count;

  modport master (
    output in_valid, in_rd, in_data, wb_stall, rs, rt,
    input  in_ready, rd, wr_data, wr_en, hz_a, hz_b, fwd_a, fwd_b, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, wb_stall, rs, rt,
    output in_ready, rd, wr_data, wr_en, hz_a, hz_b, fwd_a, fwd_b, count
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - 4-entry writeback queue with hazard detection and optional forwarding
//
// Purpose: buffers {rd, data} writebacks in arrival order and drains them into the
// register file write port when wb_stall is low. Flags pending writes to the
// decoder's rs/rt selects.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - regfile_wb_ctrl_if.slave (request handshake, write port, hazards, count)
// Configuration macro: REGFILE_WB_FWD_EN - when defined, fwd_a/fwd_b carry the data of
// the youngest live entry matching rs/rt; otherwise they are tied to 0.
module regfile_wb_ctrl (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_ctrl_if.slave  bus
);

  logic [4:0]  ent_rd_q   [4];
  logic [4:0]  ent_rd_d   [4];
  logic [31:0] ent_data_q [4];
  logic [31:0] ent_data_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;

  logic        in_ready;
  logic        push;
  logic        pop;
  logic [1:0]  age [4];
  logic [3:0]  live;
  logic [3:0]  match_a;
  logic [3:0]  match_b;

  // Readiness looks only at the registered count so it never depends on a same-cycle pop.
  always_comb begin
    in_ready = (count_q < 3'd4) && !rst;
    push     = bus.in_valid && in_ready && (bus.in_rd != 5'd0);
    pop      = (count_q != 3'd0) && !bus.wb_stall;
  end

  // age 0 is the head; an entry is live if it lies inside the occupied window and
  // is not the head leaving on this edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      age[i]     = 2'(i) - rd_ptr_q;
      live[i]    = ({1'b0, age[i]} < count_q) && !(pop && (age[i] == 2'd0));
      match_a[i] = live[i] && (bus.rs != 5'd0) && (ent_rd_q[i] == bus.rs);
      match_b[i] = live[i] && (bus.rt != 5'd0) && (ent_rd_q[i] == bus.rt);
    end
  end

  assign bus.hz_a = |match_a;
  assign bus.hz_b = |match_b;

`ifdef REGFILE_WB_FWD_EN
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // Walk from oldest to youngest so the last hit (youngest) wins.
  always_comb begin
    fwd_a = 32'd0;
    fwd_b = 32'd0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (age[i] == 2'(k)) begin
          if (match_a[i]) fwd_a = ent_data_q[i];
          if (match_b[i]) fwd_b = ent_data_q[i];
        end
      end
    end
  end

  assign bus.fwd_a = fwd_a;
  assign bus.fwd_b = fwd_b;
`else
  assign bus.fwd_a = 32'd0;
  assign bus.fwd_b = 32'd0;
`endif

  always_comb begin
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    if (push) begin
      ent_rd_d[wr_ptr_q]   = bus.in_rd;
      ent_data_d[wr_ptr_q] = bus.in_data;
    end

    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Write port only ever sees the registered head; nothing is bypassed from the input.
    wr_en_d   = pop;
    rd_d      = rd_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      rd_d      = ent_rd_q[rd_ptr_q];
      wr_data_d = ent_data_q[rd_ptr_q];
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    ent_rd_q   <= ent_rd_d;
    ent_data_q <= ent_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      rd_q      <= 5'd0;
      wr_data_q <= 32'd0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.rd       = rd_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.count    = count_q;

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, a writeback request is present.
REQ-004 SHALL have port in_ready, output, 1, the request is accepted this cycle.
REQ-005 SHALL have port in_rd, input, 5, destination register number.
REQ-006 SHALL have port in_data, input, 32, writeback data.
REQ-007 SHALL have port wb_stall, input, 1, register file cannot take a write this cycle.
REQ-008 SHALL have port rd, output, 5, register file write select (registered).
REQ-009 SHALL have port wr_data, output, 32, register file write data (registered).
REQ-010 SHALL have port wr_en, output, 1, rd and wr_data are valid this cycle (registered).
REQ-011 SHALL have ports rs and rt, input, 5 each, read selects being issued by the decoder.
REQ-012 SHALL have ports hz_a and hz_b, output, 1 each, a pending write targets rs or rt respectively.
REQ-013 SHALL have ports fwd_a and fwd_b, output, 32 each, forwarded pending data for rs and rt.
REQ-014 SHALL have port count, output, 3, pending entry count, range 0..4.

Function
REQ-015 SHALL buffer writebacks in a 4-entry FIFO holding {rd, data} and draining in arrival order.
REQ-016 SHALL drive in_ready = (count < 4) and !rst, combinationally.
- in_ready SHALL NOT depend on a same-cycle pop.
REQ-017 SHALL complete the handshake when in_valid and in_ready are both high.
- If in_rd = 0, the request SHALL be discarded and not enqueued.
- Otherwise it SHALL be enqueued at the tail.
REQ-018 SHALL pop the head when count != 0 and wb_stall = 0.
- On that edge, rd/wr_data SHALL take the head values and wr_en SHALL be 1.
- When no pop occurs, wr_en SHALL be 0 and rd/wr_data SHALL hold their previous values.
REQ-019 SHALL make an entry pushed at edge N poppable no earlier than edge N+1.
- An entry is never bypassed straight to the write port.
- Minimum latency is wr_en high in the second cycle after acceptance.
REQ-020 SHALL handle a simultaneous push and pop by leaving count unchanged.
- Push-only SHALL increment count by 1.
- Pop-only SHALL decrement count by 1.
- Pointers SHALL wrap modulo 4.
REQ-021 SHALL assert hz_a when rs != 0 and any valid FIFO entry has rd = rs; hz_b likewise for rt.
- hz_a/hz_b SHALL be combinational.
- An entry popped on the current edge SHALL no longer count toward a hazard.
REQ-022 SHALL keep writes to one register in FIFO order, so that the youngest data is written last when several entries target it.

Reset
REQ-023 SHALL, with rst high at a clock edge, force count=0, both FIFO pointers=0, wr_en=0, rd=0 and wr_data=0.
REQ-024 SHALL discard all pending entries when reset occurs mid-operation, with no write issued for them.
REQ-025 SHALL hold in_ready=0 while rst is high; hz_a, hz_b, fwd_a and fwd_b SHALL be 0 after reset.

Configuration
REQ-026 SHALL use the macro REGFILE_WB_FWD_EN to select forwarding.
- Defined: fwd_a/fwd_b SHALL give the data of the youngest valid entry matching rs/rt, and 0 when there is no match or the select is 0.
- Undefined: fwd_a and fwd_b SHALL be constant 0, no forwarding logic SHALL be built, and hz_a/hz_b SHALL be unchanged.

Verification
REQ-027 SHALL cover single write: in_rd=9, in_data=0xDEADBEEF accepted at edge 1, wb_stall=0 -> rd=9, wr_data=0xDEADBEEF, wr_en=1 after edge 2, then wr_en=0 after edge 3.
REQ-028 SHALL cover fill and backpressure: wb_stall=1 and 5 requests to regs 1..5 -> count=4, in_ready=0, 5th held; release stall -> writes to 1,2,3,4 in order, then 5 accepted.
REQ-029 SHALL cover register 0: in_rd=0 accepted -> count stays 0 and wr_en stays 0.
REQ-030 SHALL cover hazard and forward: queue {9:0x11, 9:0x22} with stall=1, rs=9 -> hz_a=1; fwd_a=0x22 with REGFILE_WB_FWD_EN, 0 without.
REQ-031 SHALL cover reset mid-operation: count=3, assert rst one cycle -> count=0, wr_en=0 and no writes for 3 cycles after release.
REQ-032 SHALL cover simultaneous push/pop: at count=4 with a pop, in_ready=0 and count becomes 3; at count=2 with push and pop, count stays 2.
